counter_updown_modn: RTL and testbench

//   Parametrised up/down counter with programmable modulus, wrap or saturate mode,

---
 rtl/counter_updown_modn.sv | 83 ++++++++
 tb/tb_counter_updown_modn.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/counter_updown_modn.sv
// Up/down modulo counter with a programmable top value, wrap or saturate behaviour
// at the boundaries, synchronous clear/load and a count enable.
module counter_updown_modn #(
    parameter int N         = 4,
    parameter int MAX_VALUE = 9,
    parameter bit SATURATE  = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         enable,
    input  logic         up_down,
    output logic [N-1:0] counter,
    output logic         wrap,
    output logic         saturated,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [N-1:0] MAX_CNT = N'(MAX_VALUE);
    localparam logic [N-1:0] ONE     = N'(1);

    logic [N-1:0] counter_next;
    logic         wrap_next;
    logic         saturated_next;

    function automatic logic [N-1:0] clamp_load(input logic [N-1:0] value);
        return (value > MAX_CNT) ? MAX_CNT : value;
    endfunction

    // Boundaries are detected by explicit compare so a full-range modulus never
    // relies on natural N-bit overflow.
    always_comb begin
        counter_next   = counter;
        wrap_next      = 1'b0;
        saturated_next = saturated;
        if (clear) begin
            counter_next   = '0;
            saturated_next = 1'b0;
        end else if (load) begin
            counter_next   = clamp_load(load_value);
            saturated_next = 1'b0;
        end else if (enable) begin
            if (up_down) begin
                if (counter < MAX_CNT) begin
                    counter_next = counter + ONE;
                end else if (SATURATE) begin
                    saturated_next = 1'b1;
                end else begin
                    counter_next = '0;
                    wrap_next    = 1'b1;
                end
            end else begin
                if (counter != '0) begin
                    counter_next = counter - ONE;
                end else if (SATURATE) begin
                    saturated_next = 1'b1;
                end else begin
                    counter_next = MAX_CNT;
                    wrap_next    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter   <= '0;
            wrap      <= 1'b0;
            saturated <= 1'b0;
        end else begin
            counter   <= counter_next;
            wrap      <= wrap_next;
            saturated <= saturated_next;
        end
    end

    assign at_max = (counter == MAX_CNT);
    assign at_min = (counter == '0);

endmodule

// File: tb/tb_counter_updown_modn.sv
// Directed bench for counter_updown_modn: a wrap-mode, a saturate-mode and a
// 3-bit full-range instance driven by shared controls, checked step by step.
module tb_counter_updown_modn;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic       load;
    logic       enable;
    logic       up_down;
    logic [3:0] lv;
    logic [2:0] lv3;

    logic [3:0] c_w, c_s;
    logic [2:0] c_3;
    logic       w_w, s_w, mx_w, mn_w;
    logic       w_s, s_s, mx_s, mn_s;
    logic       w_3, s_3, mx_3, mn_3;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    counter_updown_modn #(.N(4), .MAX_VALUE(9), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv),
        .enable(enable), .up_down(up_down), .counter(c_w), .wrap(w_w),
        .saturated(s_w), .at_max(mx_w), .at_min(mn_w)
    );

    counter_updown_modn #(.N(4), .MAX_VALUE(9), .SATURATE(1'b1)) u_sat (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv),
        .enable(enable), .up_down(up_down), .counter(c_s), .wrap(w_s),
        .saturated(s_s), .at_max(mx_s), .at_min(mn_s)
    );

    counter_updown_modn #(.N(3), .MAX_VALUE(7), .SATURATE(1'b0)) u_n3 (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv3),
        .enable(enable), .up_down(up_down), .counter(c_3), .wrap(w_3),
        .saturated(s_3), .at_max(mx_3), .at_min(mn_3)
    );

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; up_down = 1'b0;
        lv = 4'd0; lv3 = 3'd0;

        // Reset state
        #12;
        chk4("rst_cnt_w", c_w, 4'd0);
        chk1("rst_wrap_w", w_w, 1'b0);
        chk1("rst_sat_s", s_s, 1'b0);
        chk1("rst_atmin_w", mn_w, 1'b1);
        chk1("rst_atmax_w", mx_w, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Count up 12 edges on all three instances
        enable = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk4($sformatf("up_cnt_w_%0d", i), c_w, 4'(i % 10));
            chk1($sformatf("up_wrap_w_%0d", i), w_w, (i == 10));
            chk4($sformatf("up_cnt_s_%0d", i), c_s, 4'((i > 9) ? 9 : i));
            chk1($sformatf("up_sat_s_%0d", i), s_s, (i >= 10));
            chk1($sformatf("up_wrap_s_%0d", i), w_s, 1'b0);
            chk4($sformatf("up_cnt_3_%0d", i), {1'b0, c_3}, 4'(i % 8));
            chk1($sformatf("up_wrap_3_%0d", i), w_3, (i == 8));
        end
        chk1("wrapmode_never_sat", s_w, 1'b0);
        chk1("sat_atmax", mx_s, 1'b1);

        // Load clears the saturated flag
        enable = 1'b0; load = 1'b1; lv = 4'd3; lv3 = 3'd3;
        tick();
        chk4("load3_cnt_s", c_s, 4'd3);
        chk1("load3_sat_s", s_s, 1'b0);
        chk4("load3_cnt_w", c_w, 4'd3);

        // Count down from 1 through zero
        lv = 4'd1; lv3 = 3'd1;
        tick();
        load = 1'b0; enable = 1'b1; up_down = 1'b0;
        tick();
        chk4("dn_cnt_w_0", c_w, 4'd0);
        chk1("dn_wrap_w_0", w_w, 1'b0);
        chk1("dn_atmin_w", mn_w, 1'b1);
        tick();
        chk4("dn_cnt_w_9", c_w, 4'd9);
        chk1("dn_wrap_w_9", w_w, 1'b1);
        chk1("dn_atmax_w", mx_w, 1'b1);
        chk4("dn_cnt_s_hold", c_s, 4'd0);
        chk1("dn_sat_s", s_s, 1'b1);
        chk4("dn_cnt_3_7", {1'b0, c_3}, 4'd7);
        chk1("dn_wrap_3", w_3, 1'b1);

        // Idle and up_down toggling have no effect
        enable = 1'b0;
        tick();
        chk4("idle_cnt_w", c_w, 4'd9);
        chk1("idle_wrap_w", w_w, 1'b0);
        up_down = 1'b1;
        tick();
        up_down = 1'b0;
        tick();
        chk4("toggle_cnt_w", c_w, 4'd9);
        chk1("toggle_sat_s", s_s, 1'b1);

        // Clear beats load and enable
        load = 1'b1; lv = 4'd5; lv3 = 3'd5;
        tick();
        chk4("load5_cnt_w", c_w, 4'd5);
        clear = 1'b1; load = 1'b1; enable = 1'b1; up_down = 1'b1; lv = 4'd7; lv3 = 3'd6;
        tick();
        chk4("clr_cnt_w", c_w, 4'd0);
        chk4("clr_cnt_s", c_s, 4'd0);
        chk1("clr_sat_s", s_s, 1'b0);
        chk1("clr_wrap_w", w_w, 1'b0);

        // Out-of-range load is clamped and beats enable
        clear = 1'b0; load = 1'b1; enable = 1'b1; lv = 4'd14; lv3 = 3'd7;
        tick();
        chk4("clamp_cnt_w", c_w, 4'd9);
        chk1("clamp_atmax_w", mx_w, 1'b1);
        chk1("clamp_wrap_w", w_w, 1'b0);
        chk4("load7_cnt_3", {1'b0, c_3}, 4'd7);
        chk1("load7_atmax_3", mx_3, 1'b1);
        load = 1'b0;
        tick();
        chk4("after_clamp_cnt_w", c_w, 4'd0);
        chk1("after_clamp_wrap_w", w_w, 1'b1);
        chk4("n3_full_range_cnt", {1'b0, c_3}, 4'd0);
        chk1("n3_full_range_wrap", w_3, 1'b1);
        chk1("after_clamp_sat_s", s_s, 1'b1);

        // Asynchronous reset mid-count
        enable = 1'b0; load = 1'b1; lv = 4'd6; lv3 = 3'd6;
        tick();
        load = 1'b0;
        chk4("pre_rst_cnt_w", c_w, 4'd6);
        #2 reset = 1'b0;
        #1;
        chk4("async_rst_cnt_w", c_w, 4'd0);
        chk1("async_rst_wrap_w", w_w, 1'b0);
        chk4("async_rst_cnt_s", c_s, 4'd0);
        chk1("async_rst_sat_s", s_s, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b1; up_down = 1'b1;
        tick();
        chk4("post_rst_cnt_w", c_w, 4'd1);
        enable = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
